// File: rtl/mips_isa_pkg.sv
// MIPS-style ISA constants shared by the encoder and control decoder.
// Opcodes, funct codes, in_op select encoding and encoder FSM states.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_NOR  = 4'd5,
    OP_MUL  = 4'd6,
    OP_DIV  = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9,
    OP_BEQ  = 4'd10,
    OP_BNE  = 4'd11,
    OP_J    = 4'd12,
    OP_ADDI = 4'd13,
    OP_SLTI = 4'd14,
    OP_ILL  = 4'd15
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_MUL = 6'b100001;
  localparam logic [5:0] FN_DIV = 6'b100011;

  // Program memory holds 256 words; count reaching this is full.
  localparam logic [8:0] FULL_COUNT = 9'd256;
  localparam logic [8:0] LAST_SLOT  = 9'd255;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERR
  } state_e;

  function automatic logic [31:0] rtype(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [5:0] fn
  );
    return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: in_op plus fields to a 32-bit word.
// Flags the reserved select so the FSM can refuse to write it.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  // Select the format and opcode/funct for each operation.
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    unique case (op_i)
      OP_ADD:  word_o = rtype(rs_i, rt_i, rd_i, FN_ADD);
      OP_SUB:  word_o = rtype(rs_i, rt_i, rd_i, FN_SUB);
      OP_AND:  word_o = rtype(rs_i, rt_i, rd_i, FN_AND);
      OP_OR:   word_o = rtype(rs_i, rt_i, rd_i, FN_OR);
      OP_SLT:  word_o = rtype(rs_i, rt_i, rd_i, FN_SLT);
      OP_NOR:  word_o = rtype(rs_i, rt_i, rd_i, FN_NOR);
      OP_MUL:  word_o = rtype(rs_i, rt_i, rd_i, FN_MUL);
      OP_DIV:  word_o = rtype(rs_i, rt_i, rd_i, FN_DIV);
      OP_LW:   word_o = {OPC_LW, rs_i, rt_i, imm_i};
      OP_SW:   word_o = {OPC_SW, rs_i, rt_i, imm_i};
      OP_BEQ:  word_o = {OPC_BEQ, rs_i, rt_i, imm_i};
      OP_BNE:  word_o = {OPC_BNE, rs_i, rt_i, imm_i};
      OP_J:    word_o = {OPC_J, target_i};
      OP_ADDI: word_o = {OPC_ADDI, rs_i, rt_i, imm_i};
      OP_SLTI: word_o = {OPC_SLTI, rs_i, rt_i, imm_i};
      OP_ILL:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instructions into program memory from word 0.
// One registered write slot; accepts a new request as it drains.
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        done,
  output logic        error,
  output logic [8:0]  count
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [8:0]  count_q, count_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        last_q, last_d;
  logic        lastacc_q, lastacc_d;

  logic [31:0] word;
  logic        illegal;
  logic        wr_done;
  logic        full;
  logic        ready_c;
  logic        accept;
  logic        overflow;

  instr_pack u_pack (
    .op_i      (in_op),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .target_i  (in_target),
    .word_o    (word),
    .illegal_o (illegal)
  );

  // Full also covers a pending 256th word, so no 257th is taken.
  assign wr_done  = we_q && mem_ready;
  assign full     = (count_q == FULL_COUNT) ||
                    ((count_q == LAST_SLOT) && we_q);
  assign ready_c  = (state_q == S_LOAD) && !full && !lastacc_q &&
                    (!we_q || mem_ready) && !start && !reset;
  assign accept   = in_valid && ready_c;
  assign overflow = (state_q == S_LOAD) &&
                    (count_q == FULL_COUNT) && in_valid;

  // Next-state: start wins, then drain, accept and error events.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    done_d    = done_q;
    error_d   = error_q;
    last_d    = last_q;
    lastacc_d = lastacc_q;
    if (start) begin
      state_d   = S_LOAD;
      we_d      = 1'b0;
      addr_d    = '0;
      wdata_d   = '0;
      count_d   = '0;
      done_d    = 1'b0;
      error_d   = 1'b0;
      last_d    = 1'b0;
      lastacc_d = 1'b0;
    end else begin
      if (wr_done) begin
        we_d    = 1'b0;
        count_d = count_q + 9'd1;
        if (addr_q != 8'hFF) begin
          addr_d = addr_q + 8'd1;
        end
        if (last_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      if (accept) begin
        if (illegal) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end else begin
          we_d      = 1'b1;
          wdata_d   = word;
          last_d    = in_last;
          lastacc_d = lastacc_q | in_last;
        end
      end
      if (overflow) begin
        state_d = S_ERR;
        error_d = 1'b1;
      end
    end
  end

  // State and registered outputs; reset aborts any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      last_q    <= 1'b0;
      lastacc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      count_q   <= count_d;
      done_q    <= done_d;
      error_q   <= error_d;
      last_q    <= last_d;
      lastacc_q <= lastacc_d;
    end
  end

  assign in_ready  = ready_c;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder with a queue-based memory model.
// Directed program loads plus random programs and random mem_ready.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;
  logic        mem_we, mem_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        done, error;
  logic [8:0]  count;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_target (in_target),
    .in_last   (in_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .done      (done),
    .error     (error),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    bit          last;
  } wr_t;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } lg_t;

  wr_t q[$];
  lg_t log_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_count = 0;
  int  m_nxt = 0;
  bit  m_done = 0, m_err = 0, m_load = 0, m_lastacc = 0;
  bit  acc_seen = 0;
  int  rdy_mode = 0;

  logic [5:0] fn_t [0:7] = '{6'h20, 6'h22, 6'h24, 6'h25,
                             6'h2a, 6'h27, 6'h21, 6'h23};

  function automatic logic [31:0] enc(input int op,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm,
      input logic [25:0] tgt);
    logic [5:0] opc;
    if (op < 8) return {6'd0, rs, rt, rd, 5'd0, fn_t[op]};
    if (op == 12) return {6'b000010, tgt};
    case (op)
      8:  opc = 6'b100011;
      9:  opc = 6'b101011;
      10: opc = 6'b000100;
      11: opc = 6'b000101;
      13: opc = 6'b001000;
      default: opc = 6'b001010;
    endcase
    return {opc, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_rdy();
    case (rdy_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ($urandom % 4) != 0;
      default: mem_ready = 1'b0;
    endcase
  endtask

  task automatic set_rdy(input int m);
    rdy_mode = m;
    drive_rdy();
  endtask

  // One cycle: compare at negedge, advance model, redrive after edge.
  task automatic step();
    wr_t e;
    bit  exp_rdy;
    bit  err_full;
    @(negedge clk);
    chk("count", 32'(count), 32'(m_count));
    chk("done", 32'(done), 32'(m_done));
    chk("error", 32'(error), 32'(m_err));
    chk("mem_we", 32'(mem_we), 32'(q.size() != 0));
    if (mem_we && q.size() != 0) begin
      chk("mem_addr", 32'(mem_addr), 32'(q[0].a));
      chk("mem_wdata", mem_wdata, q[0].d);
    end
    exp_rdy = m_load && !m_lastacc && (m_count + q.size() < 256) &&
              (q.size() == 0 || mem_ready) && !start && !reset;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc_seen = in_valid && in_ready;
    if (reset || start) begin
      q.delete();
      m_count = 0; m_nxt = 0;
      m_done = 0; m_err = 0; m_lastacc = 0;
      m_load = !reset;
    end else begin
      err_full = m_load && m_count == 256 && in_valid;
      if (q.size() != 0 && mem_ready) begin
        e = q.pop_front();
        log_q.push_back('{mem_addr, mem_wdata});
        m_count++;
        if (e.last) begin
          m_done = 1;
          m_load = 0;
        end
      end
      if (acc_seen) begin
        if (in_op == 4'd15) begin
          m_err = 1;
          m_load = 0;
        end else begin
          q.push_back('{8'(m_nxt),
            enc(int'(in_op), in_rs, in_rt, in_rd, in_imm, in_target),
            in_last});
          m_nxt++;
          if (in_last) m_lastacc = 1;
        end
      end
      if (err_full) begin
        m_err = 1;
        m_load = 0;
      end
    end
    @(posedge clk);
    #1;
    drive_rdy();
  endtask

  task automatic send(input int op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd,
      input logic [15:0] imm, input logic [25:0] tgt,
      input bit last);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_op = 4'(op); in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt; in_last = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (acc_seen) ok = 1;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_rand(input int op, input bit last);
    send(op, 5'($urandom), 5'($urandom), 5'($urandom),
         16'($urandom), 26'($urandom), last);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && q.size() != 0; i++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
    step();
    step();
  endtask

  task automatic do_start();
    log_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int  n;
  int  op;
  bit  bad;

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_imm = '0; in_target = '0; in_last = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    step();
    reset = 1'b0;
    step();

    chk("pin_add", enc(0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0), 32'h00221820);
    chk("pin_lw", enc(8, 5'd29, 5'd8, 5'd0, 16'd4, 26'd0), 32'h8FA80004);

    // single ADD with last
    set_rdy(0);
    do_start();
    send(0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1);
    drain();
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_nlog", 32'(log_q.size()), 32'd1);
    if (log_q.size() >= 1) begin
      chk("t1_addr", 32'(log_q[0].a), 32'd0);
      chk("t1_data", log_q[0].d, 32'h00221820);
    end

    // LW, J, BEQ at full throughput
    do_start();
    send(8, 5'd29, 5'd8, 5'd17, 16'd4, 26'h3ffffff, 0);
    send(12, 5'd31, 5'd31, 5'd31, 16'hffff, 26'h10, 0);
    send(10, 5'd1, 5'd2, 5'd9, 16'hffff, 26'h0, 1);
    drain();
    chk("t2_nlog", 32'(log_q.size()), 32'd3);
    if (log_q.size() >= 3) begin
      chk("t2_d0", log_q[0].d, 32'h8FA80004);
      chk("t2_d1", log_q[1].d, 32'h08000010);
      chk("t2_d2", log_q[2].d, 32'h1022FFFF);
      chk("t2_a2", 32'(log_q[2].a), 32'd2);
    end
    chk("t2_done", 32'(done), 32'd1);

    // stall with mem_ready low for 3 cycles
    do_start();
    set_rdy(2);
    send(0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 0);
    in_valid = 1'b1; in_op = 4'd1;
    in_rs = 5'd7; in_rt = 5'd8; in_rd = 5'd9; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_we", 32'(mem_we), 32'd1);
      chk("t3_addr", 32'(mem_addr), 32'd0);
      chk("t3_data", mem_wdata,
          enc(0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0));
      chk("t3_rdy", 32'(in_ready), 32'd0);
    end
    set_rdy(0);
    send(1, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1);
    drain();
    chk("t3_count", 32'(count), 32'd2);
    chk("t3_nlog", 32'(log_q.size()), 32'd2);
    if (log_q.size() >= 2)
      chk("t3_d1", log_q[1].d, enc(1, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0));

    // illegal op as second word
    do_start();
    set_rdy(1);
    send_rand(3, 0);
    send_rand(15, 0);
    set_rdy(0);
    drain();
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_rdy", 32'(in_ready), 32'd0);
    chk("t4_count", 32'(count), 32'd1);
    chk("t4_nlog", 32'(log_q.size()), 32'd1);

    // fill 256 words, then keep requesting
    do_start();
    set_rdy(1);
    for (int i = 0; i < 256; i++) send_rand($urandom_range(0, 14), 0);
    in_valid = 1'b1; in_op = 4'd2; in_last = 1'b0;
    for (int i = 0; i < 60 && !error; i++) step();
    in_valid = 1'b0;
    step();
    chk("t5_error", 32'(error), 32'd1);
    chk("t5_count", 32'(count), 32'd256);
    chk("t5_nlog", 32'(log_q.size()), 32'd256);
    chk("t5_we", 32'(mem_we), 32'd0);
    if (log_q.size() >= 256)
      chk("t5_a255", 32'(log_q[255].a), 32'd255);

    // start aborts a pending write, start beats in_valid
    do_start();
    set_rdy(2);
    send_rand(4, 0);
    chk("t6_we_pend", 32'(mem_we), 32'd1);
    start = 1'b1; in_valid = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b0;
    chk("t6_we", 32'(mem_we), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_addr", 32'(mem_addr), 32'd0);
    send_rand(5, 0);
    chk("t6_we_pend2", 32'(mem_we), 32'd1);
    step();
    step();
    chk("t6_cnt_hold", 32'(count), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6r_we", 32'(mem_we), 32'd0);
    chk("t6r_count", 32'(count), 32'd0);
    chk("t6r_addr", 32'(mem_addr), 32'd0);
    chk("t6r_rdy", 32'(in_ready), 32'd0);
    step();

    // random programs
    for (int p = 0; p < 8; p++) begin
      do_start();
      set_rdy(1);
      n = $urandom_range(3, 24);
      bad = 0;
      for (int i = 0; i < n && !bad; i++) begin
        op = ($urandom % 12 == 0) ? 15 : $urandom_range(0, 14);
        send_rand(op, i == n - 1);
        if (op == 15) bad = 1;
      end
      set_rdy(0);
      drain();
      chk("t7_error", 32'(error), 32'(bad));
      chk("t7_done", 32'(done), 32'(!bad));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
